// File: rtl/alu_arbiter.sv
// Two-requester front end to a shared 32-bit ALU: round-robin or fixed-priority grant,
// valid/ready handshakes on both sides, one transaction in flight, registered result.
module alu_arbiter #(
    parameter int unsigned WIDTH       = 32,
    parameter bit          ROUND_ROBIN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic             last_grant;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;

    logic             gnt_any;
    logic             gnt_id;
    logic [WIDTH-1:0] diff;
    logic             ovf;
    logic [WIDTH-1:0] alu_res;

    // On a tie, round-robin favours whoever was not served last; fixed mode favours req0.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        gnt_id  = 1'b0;
        if (req0_valid && req1_valid)
            gnt_id = ROUND_ROBIN ? ~last_grant : 1'b0;
        else
            gnt_id = req1_valid;
    end

    assign req0_ready = !reset && (state == IDLE) && gnt_any && !gnt_id;
    assign req1_ready = !reset && (state == IDLE) && gnt_any &&  gnt_id;

    // Signed less-than from the subtractor's sign bit corrected for overflow.
    always_comb begin
        diff    = a_q + ~b_q + WIDTH'(1);
        ovf     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
        alu_res = '0;
        case (op_q)
            3'b000:  alu_res = a_q & b_q;
            3'b001:  alu_res = a_q | b_q;
            3'b010:  alu_res = a_q + b_q;
            3'b110:  alu_res = diff;
            3'b111:  alu_res[0] = diff[WIDTH-1] ^ ovf;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        id_q  <= gnt_id;
                        op_q  <= gnt_id ? req1_op : req0_op;
                        a_q   <= gnt_id ? req1_a  : req0_a;
                        b_q   <= gnt_id ? req1_b  : req0_b;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_res;
                    rsp_zero   <= (alu_res == '0);
                    rsp_id     <= id_q;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= rsp_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected {id,result,zero} queued at stimulus time,
// popped and compared when a response appears.
module tb_alu_arbiter;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [W-1:0] rsp_result;

    logic         fp_req0_valid, fp_req1_valid, fp_req0_ready, fp_req1_ready;
    logic [2:0]   fp_req0_op, fp_req1_op;
    logic [W-1:0] fp_req0_a, fp_req0_b, fp_req1_a, fp_req1_b;
    logic         fp_rsp_valid, fp_rsp_ready, fp_rsp_id, fp_rsp_zero;
    logic [W-1:0] fp_rsp_result;

    int total = 0;
    int bad   = 0;
    logic [W+1:0] q [$];
    logic [W+1:0] fp_q [$];

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    alu_arbiter #(.WIDTH(W), .ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready), .req0_op(fp_req0_op), .req0_a(fp_req0_a), .req0_b(fp_req0_b),
        .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready), .req1_op(fp_req1_op), .req1_a(fp_req1_a), .req1_b(fp_req1_b),
        .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_id(fp_rsp_id), .rsp_result(fp_rsp_result), .rsp_zero(fp_rsp_zero)
    );

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: return '0;
        endcase
    endfunction

    function automatic logic [W+1:0] expect_of(input logic id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = model(op, a, b);
        return {id, r, (r == '0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request, wait for its grant, then scramble its inputs and collect the response.
    task automatic do_op(input logic r, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic         got;
        logic [W+1:0] exp;
        got = 1'b0;
        if (!r) begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
        else    begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
        #1;
        for (int i = 0; i < 20 && !got; i++) begin
            if ((r ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
            else tick();
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s grant: ready never rose within 20 cycles, required 1", tag);
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        q.push_back(expect_of(r, op, a, b));
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rsp_valid === 1'b1) got = 1'b1;
            else tick();
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s rsp: rsp_valid never rose within 20 cycles, required 1", tag);
            void'(q.pop_front());
            return;
        end
        exp = q.pop_front();
        if ({rsp_id, rsp_result, rsp_zero} !== exp) begin
            bad++;
            $display("FAIL %s: id=%0d result=%h zero=%0d, required id=%0d result=%h zero=%0d",
                     tag, rsp_id, rsp_result, rsp_zero, exp[W+1], exp[W:1], exp[0]);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 3'b010; req1_op = 3'b010;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        fp_req0_valid = 1'b0; fp_req1_valid = 1'b0; fp_rsp_ready = 1'b1;
        fp_req0_op = 3'b010; fp_req1_op = 3'b010;
        fp_req0_a = '0; fp_req0_b = '0; fp_req1_a = '0; fp_req1_b = '0;
        tick();
        total++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready: ready=%b, required 00", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        total++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b0, 1'b0, {W{1'b0}}, 1'b1}) begin
            bad++;
            $display("FAIL reset_outputs: valid=%0d id=%0d result=%h zero=%0d, required 0 0 0 1",
                     rsp_valid, rsp_id, rsp_result, rsp_zero);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add();
        logic [W+1:0] exp;
        req0_op = 3'b010; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
        #1;
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL add_grant: ready0=%0d ready1=%0d, required 1 0", req0_ready, req1_ready);
        end
        q.push_back(expect_of(1'b0, 3'b010, 32'd5, 32'd7));
        tick();
        total++;
        if (req0_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL add_exec: ready0=%0d rsp_valid=%0d, required 0 0", req0_ready, rsp_valid);
        end
        req0_valid = 1'b0; req0_a = 32'hDEAD_BEEF; req0_b = 32'h1234_5678;
        tick();
        exp = q.pop_front();
        total++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, exp}) begin
            bad++;
            $display("FAIL add_rsp: valid=%0d id=%0d result=%h zero=%0d, required 1 %0d %h %0d",
                     rsp_valid, rsp_id, rsp_result, rsp_zero, exp[W+1], exp[W:1], exp[0]);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL add_done: rsp_valid=%0d, required 0", rsp_valid);
        end
    endtask

    task automatic test_sub_and();
        do_op(1'b0, 3'b110, 32'd3, 32'd5, "sub_neg");
        do_op(1'b1, 3'b110, 32'd9, 32'd9, "sub_zero");
        do_op(1'b0, 3'b000, 32'h0000_F0F0, 32'h0000_FF00, "and");
        do_op(1'b1, 3'b001, 32'h0000_000F, 32'hF000_0000, "or");
        do_op(1'b0, 3'b010, 32'hFFFF_FFFF, 32'd1, "add_wrap");
    endtask

    task automatic test_slt();
        do_op(1'b0, 3'b111, 32'hFFFF_FFFF, 32'd1, "slt_neg_pos");
        do_op(1'b1, 3'b111, 32'h7FFF_FFFF, 32'h8000_0000, "slt_ovf");
        do_op(1'b0, 3'b111, 32'h8000_0000, 32'd1, "slt_min");
        do_op(1'b1, 3'b011, 32'h1234_5678, 32'd1, "undef_op");
    endtask

    // Full reset first so the tie-break starts from req0 regardless of earlier traffic.
    task automatic test_round_robin();
        int           seen;
        logic [W+1:0] exp;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        q.push_back(expect_of(1'b0, 3'b010, 32'd1, 32'd1));
        q.push_back(expect_of(1'b1, 3'b010, 32'd2, 32'd2));
        q.push_back(expect_of(1'b0, 3'b010, 32'd1, 32'd1));
        req0_op = 3'b010; req0_a = 32'd1; req0_b = 32'd1;
        req1_op = 3'b010; req1_a = 32'd2; req1_b = 32'd2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && seen < 3; i++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                exp = q.pop_front();
                seen++;
                total++;
                if ({rsp_id, rsp_result, rsp_zero} !== exp) begin
                    bad++;
                    $display("FAIL rr_%0d: id=%0d result=%h, required id=%0d result=%h",
                             seen, rsp_id, rsp_result, exp[W+1], exp[W:1]);
                end
                if (seen == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            end
        end
        total++;
        if (seen != 3) begin
            bad++;
            $display("FAIL rr_count: responses=%0d, required 3", seen);
            q.delete();
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
        tick();
    endtask

    task automatic test_fixed_priority();
        int           seen;
        logic [W+1:0] exp;
        for (int k = 0; k < 3; k++) fp_q.push_back(expect_of(1'b0, 3'b010, 32'd3, 32'd4));
        fp_req0_a = 32'd3; fp_req0_b = 32'd4; fp_req1_a = 32'd10; fp_req1_b = 32'd10;
        fp_req0_valid = 1'b1; fp_req1_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && seen < 3; i++) begin
            tick();
            if (fp_rsp_valid === 1'b1) begin
                exp = fp_q.pop_front();
                seen++;
                total++;
                if ({fp_rsp_id, fp_rsp_result, fp_rsp_zero} !== exp) begin
                    bad++;
                    $display("FAIL fixed_%0d: id=%0d result=%h, required id=%0d result=%h",
                             seen, fp_rsp_id, fp_rsp_result, exp[W+1], exp[W:1]);
                end
                if (seen == 3) begin fp_req0_valid = 1'b0; fp_req1_valid = 1'b0; end
            end
        end
        total++;
        if (seen != 3) begin
            bad++;
            $display("FAIL fixed_count: responses=%0d, required 3", seen);
            fp_q.delete();
            fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic         got;
        logic [W+1:0] exp;
        rsp_ready = 1'b0;
        req1_op = 3'b001; req1_a = 32'h0000_000F; req1_b = 32'h0000_00F0; req1_valid = 1'b1;
        #1;
        total++;
        if (req1_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_grant: ready1=%0d, required 1", req1_ready);
        end
        q.push_back(expect_of(1'b1, 3'b001, 32'h0000_000F, 32'h0000_00F0));
        tick();
        req0_op = 3'b010; req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rsp_valid === 1'b1) got = 1'b1;
            else tick();
        end
        exp = q.pop_front();
        for (int c = 0; c < 5; c++) begin
            total++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_zero, req0_ready, req1_ready} !== {1'b1, exp, 2'b00}) begin
                bad++;
                $display("FAIL bp_hold_%0d: valid=%0d id=%0d result=%h zero=%0d ready=%b, required 1 %0d %h %0d 00",
                         c, rsp_valid, rsp_id, rsp_result, rsp_zero, {req0_ready, req1_ready}, exp[W+1], exp[W:1], exp[0]);
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: rsp_valid=%0d, required 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int           seen;
        logic [W+1:0] exp;
        q.push_back(expect_of(1'b1, 3'b010, 32'd6, 32'd6));
        q.push_back(expect_of(1'b1, 3'b010, 32'd6, 32'd6));
        req1_op = 3'b010; req1_a = 32'd6; req1_b = 32'd6; req1_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 30 && seen < 2; i++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                exp = q.pop_front();
                seen++;
                total++;
                if ({rsp_id, rsp_result, rsp_zero} !== exp) begin
                    bad++;
                    $display("FAIL b2b_%0d: id=%0d result=%h, required id=%0d result=%h",
                             seen, rsp_id, rsp_result, exp[W+1], exp[W:1]);
                end
                if (seen == 2) req1_valid = 1'b0;
            end
        end
        total++;
        if (seen != 2) begin
            bad++;
            $display("FAIL b2b_count: responses=%0d, required 2", seen);
            q.delete();
            req1_valid = 1'b0;
        end
        tick();
    endtask

    task automatic test_reset_in_exec();
        req0_op = 3'b010; req0_a = 32'd1; req0_b = 32'd2; req0_valid = 1'b1;
        #1;
        total++;
        if (req0_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_exec_grant: ready0=%0d, required 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if ({rsp_valid, rsp_result} !== {1'b0, {W{1'b0}}}) begin
                bad++;
                $display("FAIL rst_exec_quiet_%0d: valid=%0d result=%h, required 0 0", c, rsp_valid, rsp_result);
            end
        end
        do_op(1'b0, 3'b010, 32'd4, 32'd4, "rst_exec_next");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_and();
        test_slt();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_back_to_back();
        test_reset_in_exec();
        total++;
        if (q.size() != 0 || fp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending=%0d/%0d, required 0/0", q.size(), fp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
